// File: rtl/multiplier_control_unit.sv
// Sequencing FSM for the unsigned shift-add multiplier (LOAD, then ADD/SHIFT x DATA_WIDTH, then DONE).
// Optional abort input enabled by defining MULT_CTRL_ABORT_EN.
module multiplier_control_unit #(
    parameter  int DATA_WIDTH = 32,
    localparam int CNT_W      = $clog2(DATA_WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             product_lsb,
`ifdef MULT_CTRL_ABORT_EN
    input  logic             abort,
`endif
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             w_ctrl_Multiplicand,
    output logic             w_ctrl_Product_init,
    output logic             alu_add_en,
    output logic             w_ctrl_Product_shift,
    output logic [CNT_W-1:0] iter_count
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ADD,
        SHIFT,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_WIDTH);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc    = cnt_q + 1'b1;
    assign iter_count = cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d              = state_q;
        cnt_d                = cnt_q;
        ready                = 1'b0;
        busy                 = 1'b0;
        done                 = 1'b0;
        w_ctrl_Multiplicand  = 1'b0;
        w_ctrl_Product_init  = 1'b0;
        alu_add_en           = 1'b0;
        w_ctrl_Product_shift = 1'b0;

        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (start) state_d = LOAD;
            end
            LOAD: begin
                busy                = 1'b1;
                w_ctrl_Multiplicand = 1'b1;
                w_ctrl_Product_init = 1'b1;
                cnt_d               = '0;
                state_d             = ADD;
            end
            ADD: begin
                busy       = 1'b1;
                alu_add_en = product_lsb;
                state_d    = SHIFT;
            end
            SHIFT: begin
                busy                 = 1'b1;
                w_ctrl_Product_shift = 1'b1;
                cnt_d                = cnt_inc;
                state_d              = (cnt_inc < LAST) ? ADD : DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

`ifdef MULT_CTRL_ABORT_EN
        // Abort overrides the normal decode: datapath enables are suppressed in the abort cycle itself.
        if (abort && (state_q inside {LOAD, ADD, SHIFT})) begin
            state_d              = IDLE;
            cnt_d                = '0;
            w_ctrl_Multiplicand  = 1'b0;
            w_ctrl_Product_init  = 1'b0;
            alu_add_en           = 1'b0;
            w_ctrl_Product_shift = 1'b0;
        end
`endif
    end

endmodule

// File: tb/tb_multiplier_control_unit.sv
// Scoreboard bench for multiplier_control_unit: stimulus pushes expected completions, a monitor checks each done pulse.
module tb_multiplier_control_unit;

    localparam int W   = 32;
    localparam int CW  = $clog2(W) + 1;
    localparam int W4  = 4;
    localparam int CW4 = $clog2(W4) + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, product_lsb;
    logic          ready, busy, done, w_mc, w_pi, alu_add_en, w_ps;
    logic [CW-1:0] iter_count;
    logic          abort;

    logic           start4, lsb4;
    logic           ready4, busy4, done4, w_mc4, w_pi4, alu4, w_ps4;
    logic [CW4-1:0] iter4;
    logic           abort4;

    int lsb_mode = 0;
    logic rnd_lsb = 1'b0;

    // 1: lsb=1 on even iteration index, 2: always 1, 3: random, else 0
    always_comb begin
        case (lsb_mode)
            1:       product_lsb = ~iter_count[0];
            2:       product_lsb = 1'b1;
            3:       product_lsb = rnd_lsb;
            default: product_lsb = 1'b0;
        endcase
    end

    multiplier_control_unit #(.DATA_WIDTH(W)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .product_lsb         (product_lsb),
`ifdef MULT_CTRL_ABORT_EN
        .abort               (abort),
`endif
        .ready               (ready),
        .busy                (busy),
        .done                (done),
        .w_ctrl_Multiplicand (w_mc),
        .w_ctrl_Product_init (w_pi),
        .alu_add_en          (alu_add_en),
        .w_ctrl_Product_shift(w_ps),
        .iter_count          (iter_count)
    );

    multiplier_control_unit #(.DATA_WIDTH(W4)) dut4 (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start4),
        .product_lsb         (lsb4),
`ifdef MULT_CTRL_ABORT_EN
        .abort               (abort4),
`endif
        .ready               (ready4),
        .busy                (busy4),
        .done                (done4),
        .w_ctrl_Multiplicand (w_mc4),
        .w_ctrl_Product_init (w_pi4),
        .alu_add_en          (alu4),
        .w_ctrl_Product_shift(w_ps4),
        .iter_count          (iter4)
    );

    int checks = 0;
    int failures = 0;
    int edge_cnt = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        int done_edge;
        int adds;
        int shifts;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Monitor: tracks enable activity per operation and scores every done pulse.
    initial begin
        int adds_seen, shifts_seen;
        exp_t e;
        adds_seen = 0;
        shifts_seen = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (w_pi) begin
                    adds_seen = 0;
                    shifts_seen = 0;
                end
                if (alu_add_en) adds_seen++;
                if (w_ps) shifts_seen++;
                check("status_onehot", int'(ready) + int'(busy) + int'(done), 1);
                if (done) begin
                    if (sb.size() == 0) begin
                        check("unexpected_done", int'(done), 0);
                    end else begin
                        e = sb.pop_front();
                        check("done_cycle", edge_cnt, e.done_edge);
                        check("done_iter_count", int'(iter_count), W);
                        check("add_count", adds_seen, e.adds);
                        check("shift_count", shifts_seen, e.shifts);
                    end
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, int'(ready), 1);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_enables"}, int'({w_mc, w_pi, alu_add_en, w_ps}), 0);
        check({tag, "_iter"}, int'(iter_count), 0);
    endtask

    task automatic wait_ready(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ready) break;
        end
        check("ready_reached", int'(ready), 1);
    endtask

    task automatic start_op(input int adds);
        exp_t e;
        wait_ready(3 * W + 10);
        start = 1'b1;
        e.done_edge = edge_cnt + 2 * W + 2;
        e.adds = adds;
        e.shifts = W;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        check("load_multiplicand", int'(w_mc), 1);
        check("load_product_init", int'(w_pi), 1);
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sb.size() == 0) break;
        end
        check("ops_completed", sb.size(), 0);
    endtask

    initial begin
        int k;
        bit found;
        rst = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        start4 = 1'b0;
        lsb4 = 1'b0;
        abort4 = 1'b0;

        // Reset with random inputs, then idle after release
        lsb_mode = 3;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start = 1'($urandom);
            rnd_lsb = 1'($urandom);
            #1 check_reset_outputs("in_reset");
        end
        @(negedge clk);
        start = 1'b0;
        lsb_mode = 0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("idle_after_reset");

        // Alternating multiplier bits: 16 adds
        lsb_mode = 1;
        start_op(16);
        wait_done(3 * W);
        check("iter_saturated", int'(iter_count), W);

        // Start held high: back-to-back operations, second starts at first IDLE after DONE
        lsb_mode = 0;
        wait_ready(10);
        start = 1'b1;
        k = edge_cnt;
        sb.push_back('{k + 2 * W + 2, 0, W});
        sb.push_back('{k + 4 * W + 5, 0, W});
        repeat (100) @(negedge clk);
        start = 1'b0;
        wait_done(200);

        // Asynchronous reset during SHIFT at iter_count=10, then a clean restart
        lsb_mode = 1;
        start_op(16);
        found = 1'b0;
        for (int i = 0; i < 3 * W; i++) begin
            @(negedge clk);
            if (w_ps && iter_count == CW'(10)) begin
                found = 1'b1;
                break;
            end
        end
        check("reached_shift_10", int'(found), 1);
        rst = 1'b0;
        sb.delete();
        #1 check_reset_outputs("mid_op_reset");
        @(negedge clk);
        rst = 1'b1;
        start_op(16);
        wait_done(3 * W);

        // Multiplier bits all zero: no adds, same latency
        lsb_mode = 0;
        start_op(0);
        wait_done(3 * W);

        // Narrow build: DONE in cycle 2*4+2
        @(negedge clk);
        check("w4_ready", int'(ready4), 1);
        start4 = 1'b1;
        k = edge_cnt;
        @(negedge clk);
        start4 = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (done4) break;
            @(negedge clk);
        end
        check("w4_done_cycle", edge_cnt - k, 2 * W4 + 2);
        check("w4_iter_count", int'(iter4), W4);

`ifdef MULT_CTRL_ABORT_EN
        // Abort during ADD of iteration 5 with lsb=1
        lsb_mode = 2;
        wait_ready(10);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 3 * W; i++) begin
            @(negedge clk);
            if (busy && !w_ps && !w_pi && iter_count == CW'(5)) begin
                found = 1'b1;
                break;
            end
        end
        check("reached_add_5", int'(found), 1);
        abort = 1'b1;
        #1 check("abort_add_en", int'(alu_add_en), 0);
        check("abort_shift", int'(w_ps), 0);
        @(negedge clk);
        abort = 1'b0;
        check("abort_ready", int'(ready), 1);
        check("abort_iter", int'(iter_count), 0);
        check("abort_done", int'(done), 0);

        // Abort and start together in LOAD
        start = 1'b1;
        @(negedge clk);
        abort = 1'b1;
        #1 check("abort_load_enables", int'({w_mc, w_pi, alu_add_en, w_ps}), 0);
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        check("abort_load_ready", int'(ready), 1);
        check("abort_load_iter", int'(iter_count), 0);
        repeat (3 * W) @(negedge clk);
        lsb_mode = 0;
`endif

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
